// File: rtl/alu_pkg.sv
// Shared ALU constants and the rotate-right sequencer state type.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    // 2'b11 is unused; the sequencer steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        DONE = 2'b10
    } ror_state_t;

endpackage : alu_pkg

// File: rtl/ror_seq.sv
// Multi-cycle rotate-right unit: rotates Rb right by Rc, one bit per clock.
// Ports:
//   clock - rising-edge clock
//   clear - asynchronous active-low reset
//   start - request, sampled only in IDLE
//   Rb    - operand, captured on the accepting edge
//   Rc    - rotate-right amount, captured on the accepting edge
//   Ra    - registered result, held until the next completion
//   busy  - high while rotating
//   done  - one-cycle pulse when Ra has been updated
module ror_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned AMT_W = SHAMT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] Rb,
    input  logic [AMT_W-1:0] Rc,
    output logic [WIDTH-1:0] Ra,
    output logic             busy,
    output logic             done
);

    ror_state_t       r_state;
    ror_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_step;
    logic             w_capture;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // State register; busy/done are registered alongside it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = IDLE;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ROT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ROT: begin
                if (r_cnt != '0) begin
                    w_step      = 1'b1;
                    w_state_nxt = ROT;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == ROT);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // Work register, countdown and result register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_work <= '0;
            r_cnt  <= '0;
            Ra     <= '0;
        end else begin
            if (w_load) begin
                r_work <= Rb;
                r_cnt  <= Rc;
            end else if (w_step) begin
                r_work <= {r_work[0], r_work[WIDTH-1:1]};
                r_cnt  <= r_cnt - AMT_W'(1);
            end
            if (w_capture) begin
                Ra <= r_work;
            end
        end
    end

endmodule : ror_seq

// File: tb/tb_ror_seq.sv
// Self-checking bench for ror_seq: vector table, scoreboard queue, corner sequences.
module tb_ror_seq;

    localparam int unsigned W = 32;
    localparam int unsigned A = 5;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [W-1:0] Rb;
    logic [A-1:0] Rc;
    logic [W-1:0] Ra;
    logic         busy;
    logic         done;

    int errs   = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [W-1:0] rb;
        logic [A-1:0] rc;
        logic [W-1:0] exp_ra;
    } vec_t;

    vec_t vecs[6];

    ror_seq #(.WIDTH(W), .AMT_W(A)) dut (
        .clock(clock), .clear(clear), .start(start),
        .Rb(Rb), .Rc(Rc), .Ra(Ra), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] rol(input logic [W-1:0] x, input int unsigned s);
        if (s == 0) return x;
        return (x << s) | (x >> (W - s));
    endfunction

    function automatic logic [W-1:0] ref_ror(input logic [W-1:0] x, input int unsigned rc);
        return rol(x, (W - rc) % W);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request for a single cycle and record the expected result.
    task automatic issue(input logic [W-1:0] rb, input logic [A-1:0] rc, input logic [W-1:0] exp);
        @(negedge clock);
        start = 1'b1;
        Rb    = rb;
        Rc    = rc;
        sb.push_back(exp);
        @(posedge clock);
        #1;
        start = 1'b0;
        Rb    = $urandom;
        Rc    = A'($urandom);
    endtask

    // Count negedges until done (bounded); lat = 0 means timeout.
    task automatic wait_done(output int lat, output int bcnt, output bit stable);
        logic [W-1:0] ra0;
        ra0    = Ra;
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            if (Ra !== ra0) stable = 1'b0;
        end
    endtask

    task automatic pop_chk(input string name);
        logic [W-1:0] exp;
        exp = '0;
        if (sb.size() > 0) exp = sb.pop_front();
        chk(name, Ra, exp);
    endtask

    task automatic finish_op(input string name, input int rc);
        int lat, bcnt;
        bit stable;
        wait_done(lat, bcnt, stable);
        chk({name, "_lat"}, W'(lat), W'(rc + 2));
        chk({name, "_busycnt"}, W'(bcnt), W'(rc + 1));
        chk({name, "_ra_held"}, W'(stable), W'(1));
        chk({name, "_busy_at_done"}, W'(busy), W'(0));
        pop_chk({name, "_ra"});
        @(negedge clock);
        chk({name, "_done_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int lat, bcnt, dcnt;
        bit stable;
        logic [W-1:0] r;
        logic [A-1:0] c;

        vecs[0] = '{32'h00000001, 5'd1,  32'h80000000};
        vecs[1] = '{32'h12345678, 5'd0,  32'h12345678};
        vecs[2] = '{32'h80000001, 5'd31, 32'h00000003};
        vecs[3] = '{32'hF000000F, 5'd4,  32'hFF000000};
        vecs[4] = '{32'h0000FFFF, 5'd8,  32'hFF0000FF};
        vecs[5] = '{32'hA5A5A5A5, 5'd1,  32'hD2D2D2D2};

        clear = 1'b0;
        start = 1'b0;
        Rb    = '0;
        Rc    = '0;
        #3;
        chk("reset_ra", Ra, '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        @(negedge clock);
        clear = 1'b1;

        // Vector table.
        foreach (vecs[i]) begin
            issue(vecs[i].rb, vecs[i].rc, vecs[i].exp_ra);
            finish_op($sformatf("vec%0d", i), int'(vecs[i].rc));
        end

        // Random operands against the rotate-left reference.
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            c = A'($urandom);
            issue(r, c, ref_ror(r, int'(c)));
            finish_op($sformatf("rand%0d", i), int'(c));
        end

        // New request mid-rotation must be ignored.
        issue(32'hF000000F, 5'd4, 32'hFF000000);
        @(negedge clock);
        start = 1'b1;
        Rb    = 32'hFFFFFFFF;
        Rc    = 5'd7;
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bcnt, stable);
        chk("ignore_lat", W'(lat + 3), W'(6));
        pop_chk("ignore_ra");
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("ignore_single_done", W'(dcnt), '0);
        chk("ignore_ra_hold", Ra, 32'hFF000000);

        // Asynchronous clear mid-rotation.
        issue(32'hDEADBEEF, 5'd20, '0);
        void'(sb.pop_back());
        repeat (10) @(negedge clock);
        chk("abort_busy_before", W'(busy), W'(1));
        #2;
        clear = 1'b0;
        #1;
        chk("abort_ra", Ra, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        @(negedge clock);
        clear = 1'b1;
        issue(32'h0000FFFF, 5'd8, 32'hFF0000FF);
        finish_op("after_clear", 8);

        // start held high: back-to-back operations.
        @(negedge clock);
        start = 1'b1;
        Rb    = 32'hA5A5A5A5;
        Rc    = 5'd1;
        sb.push_back(32'hD2D2D2D2);
        @(posedge clock);
        #1;
        Rb = 32'h00000010;
        Rc = 5'd4;
        sb.push_back(32'h00000001);
        wait_done(lat, bcnt, stable);
        chk("b2b_lat1", W'(lat), W'(3));
        pop_chk("b2b_ra1");
        wait_done(lat, bcnt, stable);
        start = 1'b0;
        chk("b2b_interval", W'(lat), W'(7));
        chk("b2b_busycnt2", W'(bcnt), W'(5));
        chk("b2b_ra_held", W'(stable), W'(1));
        pop_chk("b2b_ra2");
        repeat (4) @(negedge clock);
        chk("b2b_idle_busy", W'(busy), '0);
        chk("b2b_final_ra", Ra, 32'h00000001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_ror_seq
